mips_gpio_port: RTL and testbench

//  Memory-mapped, parametrised GPIO peripheral for the CoreMips system.

---
 rtl/mips_gpio_pkg.sv | 43 ++++
 rtl/mips_gpio_port_sync.sv | 31 +++
 rtl/mips_gpio_port.sv | 137 +++++++++++++
 tb/tb_mips_gpio_port.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_gpio_pkg.sv
// Shared definitions for the CoreMips GPIO peripheral.
// Contents: default parameter values, register byte offsets, the register
// select enum and a helper that maps a bus byte address onto that enum.
package mips_gpio_pkg;

  localparam int GPIO_W_DEF      = 8;
  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 5;
  localparam int SYNC_STAGES_DEF = 2;

  localparam logic [31:0] GPIO_IN_OFS   = 32'h0000_0000;
  localparam logic [31:0] GPIO_OUT_OFS  = 32'h0000_0004;
  localparam logic [31:0] GPIO_DIR_OFS  = 32'h0000_0008;
  localparam logic [31:0] GPIO_EDGE_OFS = 32'h0000_000C;
  localparam logic [31:0] GPIO_IEN_OFS  = 32'h0000_0010;
  localparam logic [31:0] GPIO_STAT_OFS = 32'h0000_0014;

  typedef enum logic [2:0] {
    REG_IN   = 3'd0,
    REG_OUT  = 3'd1,
    REG_DIR  = 3'd2,
    REG_EDGE = 3'd3,
    REG_IEN  = 3'd4,
    REG_STAT = 3'd5,
    REG_NONE = 3'd6
  } gpio_reg_e;

  // Byte address to register select; the two byte-lane bits are masked off.
  function automatic gpio_reg_e decode_ofs(input logic [31:0] byte_addr);
    logic [31:0] word_ofs;
    word_ofs = byte_addr & 32'hFFFF_FFFC;
    case (word_ofs)
      GPIO_IN_OFS:   decode_ofs = REG_IN;
      GPIO_OUT_OFS:  decode_ofs = REG_OUT;
      GPIO_DIR_OFS:  decode_ofs = REG_DIR;
      GPIO_EDGE_OFS: decode_ofs = REG_EDGE;
      GPIO_IEN_OFS:  decode_ofs = REG_IEN;
      GPIO_STAT_OFS: decode_ofs = REG_STAT;
      default:       decode_ofs = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mips_gpio_port_sync.sv
// Per-bit flop-chain synchroniser for asynchronous pin inputs.
// Ports: clk, rst (sync, active-high), d (async inputs), q (output of last stage).
module gpio_sync #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain_r [STAGES];

  // Shift the pin values through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        chain_r[i] <= {W{1'b0}};
      end
    end else begin
      chain_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain_r[i] <= chain_r[i-1];
      end
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/mips_gpio_port.sv
// Memory-mapped bidirectional GPIO port for the CoreMips data bus.
// Ports: clk/rst (sync, active-high); bus_req/bus_we/bus_addr/bus_wdata request,
// bus_rdata/bus_ack one-cycle response; gpio_i async pins in, gpio_o/gpio_oe
// pin drive value and enable; irq level interrupt.
// Registers: IN (RO), OUT, DIR, EDGE_SEL, IRQ_EN, IRQ_STAT (write-1-to-clear).
module mips_gpio_port
  import mips_gpio_pkg::*;
#(
  parameter int GPIO_W      = GPIO_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_ack,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  logic [GPIO_W-1:0] out_r;
  logic [GPIO_W-1:0] dir_r;
  logic [GPIO_W-1:0] edge_sel_r;
  logic [GPIO_W-1:0] irq_en_r;
  logic [GPIO_W-1:0] irq_stat_r;
  logic [GPIO_W-1:0] sync_d_r;
  logic              irq_r;
  logic              ack_r;
  logic [DATA_W-1:0] rdata_r;

  logic [GPIO_W-1:0] sync_s;
  logic [GPIO_W-1:0] event_s;
  logic [GPIO_W-1:0] clr_s;
  logic [GPIO_W-1:0] stat_next_s;
  logic [GPIO_W-1:0] wdata_s;
  logic [GPIO_W-1:0] rd_val_s;
  logic              wr_s;
  gpio_reg_e         sel_s;

  gpio_sync #(
    .W      (GPIO_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_i),
    .q   (sync_s)
  );

  // Decode the bus request; bits above GPIO_W of the write data are dropped.
  always_comb begin
    sel_s   = decode_ofs(32'(bus_addr));
    wr_s    = bus_req & bus_we;
    wdata_s = GPIO_W'(bus_wdata);
  end

  // Read multiplexer; IN shows the synchronised pins whatever DIR says.
  always_comb begin
    rd_val_s = {GPIO_W{1'b0}};
    case (sel_s)
      REG_IN:   rd_val_s = sync_s;
      REG_OUT:  rd_val_s = out_r;
      REG_DIR:  rd_val_s = dir_r;
      REG_EDGE: rd_val_s = edge_sel_r;
      REG_IEN:  rd_val_s = irq_en_r;
      REG_STAT: rd_val_s = irq_stat_r;
      default:  rd_val_s = {GPIO_W{1'b0}};
    endcase
  end

  // Edge events and status update; OR-ing events in after the clear lets a
  // new event win over a simultaneous write-1-to-clear.
  always_comb begin
    if (wr_s && (sel_s == REG_STAT)) begin
      clr_s = wdata_s;
    end else begin
      clr_s = {GPIO_W{1'b0}};
    end
    event_s     = (sync_s & ~sync_d_r & ~edge_sel_r) |
                  (~sync_s & sync_d_r & edge_sel_r);
    stat_next_s = (irq_stat_r & ~clr_s) | event_s;
  end

  // Register file, edge-detect delay flop, status and interrupt registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r      <= {GPIO_W{1'b0}};
      dir_r      <= {GPIO_W{1'b0}};
      edge_sel_r <= {GPIO_W{1'b0}};
      irq_en_r   <= {GPIO_W{1'b0}};
      irq_stat_r <= {GPIO_W{1'b0}};
      sync_d_r   <= {GPIO_W{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      if (wr_s) begin
        case (sel_s)
          REG_OUT:  out_r      <= wdata_s;
          REG_DIR:  dir_r      <= wdata_s;
          REG_EDGE: edge_sel_r <= wdata_s;
          REG_IEN:  irq_en_r   <= wdata_s;
          default:  ;
        endcase
      end
      irq_stat_r <= stat_next_s;
      sync_d_r   <= sync_s;
      irq_r      <= |(irq_stat_r & irq_en_r);
    end
  end

  // Bus response: one-cycle ack after every request, read data zero on writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r   <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
    end else if (bus_req) begin
      ack_r   <= 1'b1;
      rdata_r <= bus_we ? {DATA_W{1'b0}} : DATA_W'(rd_val_s);
    end else begin
      ack_r   <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
    end
  end

  assign gpio_o    = out_r;
  assign gpio_oe   = dir_r;
  assign irq       = irq_r;
  assign bus_ack   = ack_r;
  assign bus_rdata = rdata_r;

endmodule

// File: tb/tb_mips_gpio_port.sv
// Scoreboard bench for mips_gpio_port: stimulus pushes expected read data,
// a negedge monitor compares every ack cycle against the queue.
module tb_mips_gpio_port;

  localparam logic [4:0] A_IN   = 5'h00;
  localparam logic [4:0] A_OUT  = 5'h04;
  localparam logic [4:0] A_DIR  = 5'h08;
  localparam logic [4:0] A_EDGE = 5'h0C;
  localparam logic [4:0] A_IEN  = 5'h10;
  localparam logic [4:0] A_STAT = 5'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [4:0]  bus_addr = 5'h00;
  logic [31:0] bus_wdata = 32'h0;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [7:0]  gpio_i = 8'h00;
  logic [7:0]  gpio_o;
  logic [7:0]  gpio_oe;
  logic        irq;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  logic        exp_ack = 1'b0;
  logic        mon_en = 1'b0;

  mips_gpio_port dut (
    .clk       (clk),
    .rst       (rst),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_oe   (gpio_oe),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    exp_q.push_back(32'h0);
    tick();
    bus_req = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [31:0] e);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = a;
    exp_q.push_back(e);
    tick();
    bus_req = 1'b0;
  endtask

  // Expected ack: a request seen at an edge without reset acks for one cycle.
  always @(posedge clk) exp_ack <= bus_req && !rst;

  // Monitor: check ack timing every cycle and pop expected data on each ack.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ack", {31'h0, bus_ack}, {31'h0, exp_ack});
      if (bus_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_ack: got ack with empty scoreboard at %0t", $time);
        end else begin
          chk("rdata", bus_rdata, exp_q.pop_front());
        end
      end else begin
        chk("rdata_idle", bus_rdata, 32'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // 1: reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gpio_o", {24'h0, gpio_o}, 32'h0);
    chk("rst_gpio_oe", {24'h0, gpio_oe}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_ack", {31'h0, bus_ack}, 32'h0);
    chk("rst_rdata", bus_rdata, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    bus_read(A_DIR, 32'h0);
    bus_read(A_STAT, 32'h0);

    // 2: output and direction
    bus_write(A_OUT, 32'h0000_00A5);
    chk("gpio_o_after_wr", {24'h0, gpio_o}, 32'hA5);
    bus_write(A_DIR, 32'h0000_000F);
    chk("gpio_o", {24'h0, gpio_o}, 32'hA5);
    chk("gpio_oe", {24'h0, gpio_oe}, 32'h0F);
    bus_read(A_OUT, 32'h0000_00A5);
    bus_read(A_DIR, 32'h0000_000F);
    bus_read(A_IN, 32'h0);

    // 6a: unmapped offsets and wide write
    bus_read(5'h1C, 32'h0);
    bus_write(5'h18, 32'hFFFF_FFFF);
    bus_read(5'h18, 32'h0);
    bus_read(A_OUT, 32'h0000_00A5);

    // 3: rising edge on pin 0 with interrupt enabled
    bus_write(A_IEN, 32'h1);
    gpio_i = 8'h01;
    tick();
    tick();
    bus_read(A_STAT, 32'h0);
    chk("irq_before", {31'h0, irq}, 32'h0);
    bus_read(A_STAT, 32'h1);
    chk("irq_set", {31'h0, irq}, 32'h1);
    bus_write(A_STAT, 32'h1);
    chk("irq_hold", {31'h0, irq}, 32'h1);
    tick();
    chk("irq_clr", {31'h0, irq}, 32'h0);

    // 4: falling-edge select on pin 7; a rising edge there is ignored
    bus_write(A_EDGE, 32'h80);
    gpio_i = 8'h81;
    repeat (4) tick();
    bus_read(A_STAT, 32'h0);
    bus_read(A_IN, 32'h81);
    gpio_i = 8'h01;
    tick();
    tick();
    bus_read(A_STAT, 32'h0);
    bus_read(A_STAT, 32'h80);
    chk("irq_masked", {31'h0, irq}, 32'h0);
    bus_write(A_STAT, 32'h80);
    bus_read(A_STAT, 32'h0);

    // 5: clear and new event in the same cycle
    bus_write(A_EDGE, 32'h0);
    gpio_i = 8'h00;
    repeat (4) tick();
    bus_read(A_STAT, 32'h0);
    gpio_i = 8'h01;
    tick();
    tick();
    bus_write(A_STAT, 32'h1);
    bus_read(A_STAT, 32'h1);
    bus_write(A_STAT, 32'h1);
    bus_read(A_STAT, 32'h0);

    // 6b: upper bits ignored, then reset during an ack cycle
    bus_write(A_OUT, 32'hFFFF_FFFF);
    bus_read(A_OUT, 32'h0000_00FF);
    chk("gpio_o_ff", {24'h0, gpio_o}, 32'hFF);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = A_OUT;
    exp_q.push_back(32'h0000_00FF);
    tick();
    chk("ack_pending", {31'h0, bus_ack}, 32'h1);
    rst = 1'b1;
    gpio_i = 8'h00;
    tick();
    chk("ack_dropped", {31'h0, bus_ack}, 32'h0);
    bus_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst2_gpio_o", {24'h0, gpio_o}, 32'h0);
    chk("rst2_gpio_oe", {24'h0, gpio_oe}, 32'h0);
    bus_read(A_OUT, 32'h0);
    bus_read(A_EDGE, 32'h0);
    bus_read(A_IEN, 32'h0);
    bus_read(A_STAT, 32'h0);

    repeat (2) tick();
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
